// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit adder/subtractor.
// Each stage adds one SEG_WIDTH-bit segment and hands its carry to the next
// stage. The upper operand segments still waiting to be added travel down
// the pipe with the operation, and so do the finished lower result segments.
// This gives an aligned full-width result NSEG cycles after accept.
// A single advance enable, driven by the output handshake, stalls every
// register together.
module pipelined_adder_nbit #(
  parameter int WIDTH     = 8,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_WIDTH;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // The pipe moves only when the output slot is empty or being drained.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1, so cin has no effect in that mode.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG_WIDTH;
    localparam int RW = LO + SEG_WIDTH;

    // Operand bits not yet added (this segment in the low SEG_WIDTH bits).
    logic [WIDTH-LO-1:0] a_src;
    logic [WIDTH-LO-1:0] b_src;
    logic                c_src;
    logic                v_src;
    logic [RW-1:0]       res_d;
    logic [SEG_WIDTH:0]  seg_sum;

    assign seg_sum = {1'b0, a_src[SEG_WIDTH-1:0]}
                   + {1'b0, b_src[SEG_WIDTH-1:0]}
                   + {{SEG_WIDTH{1'b0}}, c_src};

    if (k == 0) begin : g_first
      assign a_src = a;
      assign b_src = b_eff;
      assign c_src = c0;
      assign v_src = in_valid;
      assign res_d = seg_sum[SEG_WIDTH-1:0];
    end else begin : g_next
      assign a_src = g_stage[k-1].g_mid.a_q;
      assign b_src = g_stage[k-1].g_mid.b_q;
      assign c_src = g_stage[k-1].g_mid.c_q;
      assign v_src = g_stage[k-1].g_mid.v_q;
      assign res_d = {seg_sum[SEG_WIDTH-1:0], g_stage[k-1].g_mid.res_q};
    end

    if (k < NSEG - 1) begin : g_mid
      logic                v_q;
      logic                c_q;
      logic [RW-1:0]       res_q;
      logic [WIDTH-RW-1:0] a_q;
      logic [WIDTH-RW-1:0] b_q;

      // Intermediate stage: register the finished low segments, carry, and the remaining operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          res_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
        end else if (adv) begin
          v_q   <= v_src;
          c_q   <= seg_sum[SEG_WIDTH];
          res_q <= res_d;
          a_q   <= a_src[WIDTH-LO-1:SEG_WIDTH];
          b_q   <= b_src[WIDTH-LO-1:SEG_WIDTH];
        end
      end
    end else begin : g_last
      logic c_msb;

      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      assign c_msb = seg_sum[SEG_WIDTH-1] ^ a_src[SEG_WIDTH-1] ^ b_src[SEG_WIDTH-1];

      // Output stage: result fields load only with a valid operation so they hold across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (adv) begin
          out_valid_q <= v_src;
          if (v_src) begin
            sum_q  <= res_d;
            cout_q <= seg_sum[SEG_WIDTH];
            ovf_q  <= c_msb ^ seg_sum[SEG_WIDTH];
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Testbench for pipelined_adder_nbit (WIDTH = 8, SEG_WIDTH = 4, latency 2).
// A negedge monitor keeps a queue of expected results computed with plain
// integer arithmetic, and pops an entry whenever the DUT hands a result off.
module tb_pipelined_adder_nbit;

  localparam int W  = 8;
  localparam int SW = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_out  = 0;

  logic [9:0] exp_q[$];
  bit         stall_seen = 1'b0;
  logic [9:0] stall_val  = '0;
  bit         rand_done  = 1'b0;

  pipelined_adder_nbit #(.WIDTH(W), .SEG_WIDTH(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic on unsigned and signed views.
  function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb_,
                                       input logic tc, input logic ts);
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    int sr;
    logic co;
    logic ov;
    ua = int'(ta);
    ub = int'(tb_);
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    if (ts) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(tc);
      co = (r > 255);
      sr = sa + sb + int'(tc);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, co, 8'(r)};
  endfunction

  // Drive one operation from posedge+1 and hold it until it is accepted.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
    int guard;
    guard    = 0;
    a        = ta;
    b        = tb_;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: scoreboard, stall stability and handshake checks, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      n_acc     -= exp_q.size();
      exp_q.delete();
      stall_seen = 1'b0;
      check("in_reset_out_valid", out_valid, 0);
    end else begin
      if (stall_seen) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", {ovf, cout, sum}, stall_val);
      end
      if (out_valid) check("output_was_expected", exp_q.size() > 0, 1);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("result", {ovf, cout, sum}, exp_q.pop_front());
        n_out++;
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready_low", in_ready, 0);
        stall_seen = 1'b1;
        stall_val  = {ovf, cout, sum};
      end else begin
        stall_seen = 1'b0;
      end
      if (!out_valid) check("idle_in_ready_high", in_ready, 1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
    end
  end

  initial begin
    int n0;
    int guard;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_during", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Cross-segment carry, latency exactly 2
    @(posedge clk); #1;
    send(8'h0F, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("xseg_not_yet_valid", out_valid, 0);
    @(negedge clk);
    check("xseg_valid", out_valid, 1);
    check("xseg_sum", sum, 8'h10);
    check("xseg_cout", cout, 0);
    check("xseg_ovf", ovf, 0);

    // Wrap and signed overflow, back to back
    @(posedge clk); #1;
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("wrap_valid", out_valid, 1);
    check("wrap_sum", sum, 8'h00);
    check("wrap_cout", cout, 1);
    check("wrap_ovf", ovf, 0);
    @(negedge clk);
    check("ovf_valid", out_valid, 1);
    check("ovf_sum", sum, 8'h80);
    check("ovf_cout", cout, 0);
    check("ovf_ovf", ovf, 1);

    // Subtract mode
    @(posedge clk); #1;
    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    check("sub_neg_sum", sum, 8'hFE);
    check("sub_neg_cout", cout, 0);
    check("sub_neg_ovf", ovf, 0);
    @(negedge clk);
    check("sub_ovf_sum", sum, 8'h7F);
    check("sub_ovf_cout", cout, 1);
    check("sub_ovf_ovf", ovf, 1);
    @(posedge clk); #1;
    send(8'h10, 8'h10, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("sub_cin_ignored_valid", out_valid, 1);
    check("sub_cin_ignored_sum", sum, 8'h00);
    check("sub_cin_ignored_cout", cout, 1);

    // Backpressure: 4 ops, out_ready low 3 cycles once a result appears
    @(posedge clk); #1;
    out_ready = 1'b1;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        guard = 0;
        while (!out_valid && guard < 20) begin
          @(posedge clk); #1;
          guard++;
        end
        check("bp_result_appeared", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_all_delivered", n_out - n0, 4);

    // Random stream with bubbles and random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("rand_drained", exp_q.size(), 0);

    // Reset mid-flight flushes both accepted operations
    @(posedge clk); #1;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_no_output", out_valid, 0);
    end
    @(posedge clk); #1;
    send(8'h3C, 8'h45, 1'b0, 1'b0);
    @(negedge clk);
    check("post_flush_not_yet", out_valid, 0);
    @(negedge clk);
    check("post_flush_valid", out_valid, 1);
    check("post_flush_sum", sum, 8'h81);
    check("post_flush_cout", cout, 0);
    check("post_flush_ovf", ovf, 1);

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("accepted_vs_delivered", n_out, n_acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
